// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Arbitrates one single-port 12-bit frame-buffer RAM (quarter resolution,
//   one word per 4x4 pixel block) between the VGA pixel fetch, a queued host
//   write port and a fill engine that paints the whole buffer one colour.
//
// Ports
//   iVGA_CLK, iRST          pixel clock, synchronous active-high reset
//   iVGA_X/Y, iVGA_ACTIVE   current raster position and active-video flag
//   iWR_VALID/X/Y/DATA      host write request (word coordinates + RGB444)
//   oWR_READY               host FIFO can accept this cycle
//   iCLR_REQ, iCLR_COLOR    fill start pulse and fill colour
//   oBUSY                   fill engine running
//   oRAM_ADDR/WE/WDATA      registered RAM command
//   iRAM_Q                  RAM read data, one cycle after the address
//   oPIXEL                  fetched pixel word for the overlay datapath
//   oDROP                   sticky flag: out-of-range host write discarded
module vga_fb_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int ADDR_W     = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              iVGA_CLK,
  input  logic              iRST,
  input  logic [9:0]        iVGA_X,
  input  logic [8:0]        iVGA_Y,
  input  logic              iVGA_ACTIVE,
  input  logic              iWR_VALID,
  input  logic [7:0]        iWR_X,
  input  logic [6:0]        iWR_Y,
  input  logic [11:0]       iWR_DATA,
  output logic              oWR_READY,
  input  logic              iCLR_REQ,
  input  logic [11:0]       iCLR_COLOR,
  output logic              oBUSY,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic              oRAM_WE,
  output logic [11:0]       oRAM_WDATA,
  input  logic [11:0]       iRAM_Q,
  output logic [11:0]       oPIXEL,
  output logic              oDROP
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_W * FB_H - 1);
  localparam logic [ADDR_W-1:0] ROW_WORDS = ADDR_W'(FB_W);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]        LIM_X     = 8'(FB_W);
  localparam logic [6:0]        LIM_Y     = 7'(FB_H);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fill_cnt_q, fill_cnt_d;
  logic [11:0]        colour_q, colour_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [11:0]        wdata_q, wdata_d;
  logic [11:0]        pixel_q, pixel_d;
  logic               busy_q, busy_d;
  logic               drop_q, drop_d;
  logic               ready_q, ready_d;
  logic               rd_p1_q, rd_p1_d;
  logic               rd_p2_q, rd_p2_d;

  logic [ADDR_W-1:0]  fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]  fifo_addr_d [FIFO_DEPTH];
  logic [11:0]        fifo_data_q [FIFO_DEPTH];
  logic [11:0]        fifo_data_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               rd_slot_s;
  logic               in_range_s;
  logic               accept_s;
  logic               push_s;
  logic               pop_s;
  logic [ADDR_W-1:0]  host_addr_s;
  logic [ADDR_W-1:0]  read_addr_s;

  // Slot decode, host handshake and address arithmetic
  always_comb begin
    rd_slot_s   = iVGA_ACTIVE && (iVGA_X[1:0] == 2'b00);
    in_range_s  = (iWR_X < LIM_X) && (iWR_Y < LIM_Y);
    accept_s    = iWR_VALID && ready_q;
    // Out-of-range writes complete the handshake but never enter the FIFO.
    push_s      = accept_s && in_range_s;
    pop_s       = (state_q == IDLE) && !rd_slot_s && (count_q != {CNT_W{1'b0}});
    host_addr_s = ADDR_W'(iWR_Y) * ROW_WORDS + ADDR_W'(iWR_X);
    read_addr_s = ADDR_W'(iVGA_Y[8:2]) * ROW_WORDS + ADDR_W'(iVGA_X[9:2]);
  end

  // Host write FIFO: storage, pointers, occupancy, ready and drop flag
  always_comb begin
    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (push_s) begin
      fifo_addr_d[wr_ptr_q] = host_addr_s;
      fifo_data_d[wr_ptr_q] = iWR_DATA;
      wr_ptr_d              = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    ready_d = (count_d != CNT_FULL);
    drop_d  = drop_q || (accept_s && !in_range_s);
  end

  // Slot arbitration and fill engine: read beats queued writes beats fill
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    colour_d   = colour_q;
    addr_d     = addr_q;
    we_d       = 1'b0;
    wdata_d    = wdata_q;
    if (rd_slot_s) begin
      addr_d = read_addr_s;
      we_d   = 1'b0;
    end else if (pop_s) begin
      addr_d  = fifo_addr_q[rd_ptr_q];
      wdata_d = fifo_data_q[rd_ptr_q];
      we_d    = 1'b1;
    end else if (state_q == CLEAR) begin
      addr_d     = fill_cnt_q;
      wdata_d    = colour_q;
      we_d       = 1'b1;
      fill_cnt_d = fill_cnt_q + ADDR_ONE;
      if (fill_cnt_q == LAST_ADDR) begin
        state_d = IDLE;
      end else begin
        state_d = CLEAR;
      end
    end else begin
      we_d = 1'b0;
    end
    // A fill request is honoured only from IDLE; during CLEAR it is ignored.
    if ((state_q == IDLE) && iCLR_REQ) begin
      state_d    = CLEAR;
      colour_d   = iCLR_COLOR;
      fill_cnt_d = {ADDR_W{1'b0}};
    end else begin
      colour_d = colour_q;
    end
    busy_d = (state_d == CLEAR);
  end

  // Read return pipeline: address is registered, RAM adds one cycle, then capture
  always_comb begin
    rd_p1_d = rd_slot_s;
    rd_p2_d = rd_p1_q;
    if (rd_p2_q) begin
      pixel_d = iRAM_Q;
    end else begin
      pixel_d = pixel_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      state_q    <= IDLE;
      fill_cnt_q <= {ADDR_W{1'b0}};
      colour_q   <= 12'h000;
      addr_q     <= {ADDR_W{1'b0}};
      we_q       <= 1'b0;
      wdata_q    <= 12'h000;
      pixel_q    <= 12'h000;
      busy_q     <= 1'b0;
      drop_q     <= 1'b0;
      ready_q    <= 1'b1;
      rd_p1_q    <= 1'b0;
      rd_p2_q    <= 1'b0;
      wr_ptr_q   <= {PTR_W{1'b0}};
      rd_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {ADDR_W{1'b0}};
        fifo_data_q[i] <= 12'h000;
      end
    end else begin
      state_q     <= state_d;
      fill_cnt_q  <= fill_cnt_d;
      colour_q    <= colour_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      pixel_q     <= pixel_d;
      busy_q      <= busy_d;
      drop_q      <= drop_d;
      ready_q     <= ready_d;
      rd_p1_q     <= rd_p1_d;
      rd_p2_q     <= rd_p2_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign oWR_READY  = ready_q;
  assign oBUSY      = busy_q;
  assign oRAM_ADDR  = addr_q;
  assign oRAM_WE    = we_q;
  assign oRAM_WDATA = wdata_q;
  assign oPIXEL     = pixel_q;
  assign oDROP      = drop_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

  logic        iVGA_CLK = 1'b0;
  logic        iRST;
  logic [9:0]  iVGA_X;
  logic [8:0]  iVGA_Y;
  logic        iVGA_ACTIVE;
  logic        iWR_VALID;
  logic [7:0]  iWR_X;
  logic [6:0]  iWR_Y;
  logic [11:0] iWR_DATA;
  logic        oWR_READY;
  logic        iCLR_REQ;
  logic [11:0] iCLR_COLOR;
  logic        oBUSY;
  logic [14:0] oRAM_ADDR;
  logic        oRAM_WE;
  logic [11:0] oRAM_WDATA;
  logic [11:0] iRAM_Q;
  logic [11:0] oPIXEL;
  logic        oDROP;

  int total = 0;
  int bad   = 0;

  // RAM model and write monitors
  logic [11:0] ram [0:32767];
  int          wr_total = 0;
  logic        mon_en   = 1'b0;
  int          mon_cnt  = 0;
  int          mon_err  = 0;

  vga_fb_arbiter #(.FB_W(160), .FB_H(120), .ADDR_W(15), .FIFO_DEPTH(8)) dut (
    .iVGA_CLK(iVGA_CLK), .iRST(iRST),
    .iVGA_X(iVGA_X), .iVGA_Y(iVGA_Y), .iVGA_ACTIVE(iVGA_ACTIVE),
    .iWR_VALID(iWR_VALID), .iWR_X(iWR_X), .iWR_Y(iWR_Y), .iWR_DATA(iWR_DATA),
    .oWR_READY(oWR_READY),
    .iCLR_REQ(iCLR_REQ), .iCLR_COLOR(iCLR_COLOR), .oBUSY(oBUSY),
    .oRAM_ADDR(oRAM_ADDR), .oRAM_WE(oRAM_WE), .oRAM_WDATA(oRAM_WDATA),
    .iRAM_Q(iRAM_Q), .oPIXEL(oPIXEL), .oDROP(oDROP)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  always @(posedge iVGA_CLK) begin
    if (oRAM_WE) ram[oRAM_ADDR] <= oRAM_WDATA;
    iRAM_Q <= ram[oRAM_ADDR];
  end

  always @(posedge iVGA_CLK) begin
    if (oRAM_WE) begin
      wr_total <= wr_total + 1;
      if (mon_en) begin
        if (oRAM_ADDR !== 15'(mon_cnt) || oRAM_WDATA !== 12'h00F) mon_err <= mon_err + 1;
        mon_cnt <= mon_cnt + 1;
      end
    end
  end

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    int snap;
    for (int i = 0; i < 32768; i++) ram[i] = 12'h000;
    iRAM_Q = 12'h000;
    iRST = 1'b1; iVGA_X = 10'd0; iVGA_Y = 9'd0; iVGA_ACTIVE = 1'b0;
    iWR_VALID = 1'b0; iWR_X = 8'd0; iWR_Y = 7'd0; iWR_DATA = 12'h000;
    iCLR_REQ = 1'b0; iCLR_COLOR = 12'h000;

    // 1: reset
    tick(); tick();
    iRST = 1'b0;
    chk("rst_ready", oWR_READY, 1);
    chk("rst_busy", oBUSY, 0);
    chk("rst_we", oRAM_WE, 0);
    chk("rst_pixel", oPIXEL, 0);
    chk("rst_drop", oDROP, 0);
    chk("rst_addr", oRAM_ADDR, 0);

    // 2: blanking host write X=2 Y=3 -> address 482
    iWR_VALID = 1'b1; iWR_X = 8'd2; iWR_Y = 7'd3; iWR_DATA = 12'hF80;
    tick();
    iWR_VALID = 1'b0;
    tick();
    chk("wr_we", oRAM_WE, 1);
    chk("wr_addr", oRAM_ADDR, 482);
    chk("wr_data", oRAM_WDATA, 12'hF80);
    tick();
    chk("wr_we_off", oRAM_WE, 0);

    // 3: active read of word 482 at X=8 Y=12
    iVGA_ACTIVE = 1'b1; iVGA_Y = 9'd12; iVGA_X = 10'd8;
    tick();
    chk("rd_addr", oRAM_ADDR, 482);
    chk("rd_we", oRAM_WE, 0);
    iVGA_X = 10'd9;
    tick();
    chk("rd_pix_early", oPIXEL, 0);
    iVGA_X = 10'd10;
    tick();
    chk("rd_pixel", oPIXEL, 12'hF80);
    iVGA_X = 10'd11;
    tick();
    chk("rd_pix_hold", oPIXEL, 12'hF80);

    // 4: every cycle a READ slot; push 9 writes, 9th must be held
    iVGA_X = 10'd0; iVGA_Y = 9'd0;
    for (int i = 0; i < 8; i++) begin
      iWR_VALID = 1'b1; iWR_X = 8'(10 + i); iWR_Y = 7'd1; iWR_DATA = 12'(12'h100 + i);
      tick();
    end
    chk("fifo_full", oWR_READY, 0);
    iWR_X = 8'd18; iWR_Y = 7'd1; iWR_DATA = 12'h108;
    tick();
    chk("fifo_hold", oWR_READY, 0);
    chk("fifo_no_wr", oRAM_WE, 0);
    iVGA_ACTIVE = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 1) iWR_VALID = 1'b0;
      chk("pop_we", oRAM_WE, 1);
      chk("pop_addr", oRAM_ADDR, 32'(170 + k));
      chk("pop_data", oRAM_WDATA, 32'(12'h100 + k));
    end
    tick();
    chk("pop_done", oRAM_WE, 0);
    chk("pop_ready", oWR_READY, 1);

    // 5: fill with 0x00F; a second request mid-fill is ignored
    mon_en = 1'b1;
    iCLR_REQ = 1'b1; iCLR_COLOR = 12'h00F;
    tick();
    iCLR_REQ = 1'b0;
    chk("clr_busy", oBUSY, 1);
    tick();
    iCLR_REQ = 1'b1; iCLR_COLOR = 12'hABC;
    tick();
    iCLR_REQ = 1'b0;
    n = 0;
    while (oBUSY && n < 20000) begin
      tick();
      n++;
    end
    chk("clr_timeout", oBUSY, 0);
    tick();
    mon_en = 1'b0;
    chk("clr_count", mon_cnt, 19200);
    chk("clr_seq_err", mon_err, 0);
    chk("clr_last_addr", oRAM_ADDR, 19199);
    chk("clr_we_off", oRAM_WE, 0);
    chk("clr_ram482", ram[482], 12'h00F);
    chk("clr_ram_last", ram[19199], 12'h00F);

    // 6: out-of-range write is dropped; reset aborts a fill
    snap = wr_total;
    iWR_VALID = 1'b1; iWR_X = 8'd160; iWR_Y = 7'd0; iWR_DATA = 12'h777;
    tick();
    iWR_VALID = 1'b0;
    chk("drop_flag", oDROP, 1);
    chk("drop_ready", oWR_READY, 1);
    tick(); tick(); tick();
    chk("drop_no_wr", wr_total, snap);
    chk("drop_sticky", oDROP, 1);

    iCLR_REQ = 1'b1; iCLR_COLOR = 12'h0F0;
    tick();
    iCLR_REQ = 1'b0;
    n = 0;
    while (!(oRAM_WE && oRAM_ADDR == 15'd100) && n < 1000) begin
      tick();
      n++;
    end
    chk("fill_reach100", oRAM_ADDR, 100);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("abort_busy", oBUSY, 0);
    chk("abort_we", oRAM_WE, 0);
    chk("abort_addr", oRAM_ADDR, 0);
    chk("abort_drop", oDROP, 0);
    snap = wr_total;
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_wr", wr_total, snap);
    chk("abort_ram200", ram[200], 12'h00F);
    chk("abort_ram100", ram[100], 12'h0F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
